// File: rtl/vm_pkg.sv
// Shared types for the vending controller: coin codes, FSM states, error codes.
package vm_pkg;

  localparam int unsigned COIN_VAL_W = 16;

  typedef enum logic [2:0] {
    COIN_25   = 3'd0,
    COIN_50   = 3'd1,
    COIN_100  = 3'd2,
    COIN_500  = 3'd3,
    COIN_1000 = 3'd4,
    COIN_2000 = 3'd5,
    COIN_5000 = 3'd6,
    COIN_BAD  = 3'd7
  } coin_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } state_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BAD_COIN   = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW   = 3'd2;
  localparam logic [2:0] ERR_NOT_FOUND  = 3'd3;
  localparam logic [2:0] ERR_INSUFF     = 3'd4;
  localparam logic [2:0] ERR_BAD_PW     = 3'd5;
  localparam logic [2:0] ERR_TABLE_FULL = 3'd6;

  // Coin face value in cents; the invalid code is worth nothing.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_code_e code);
    case (code)
      COIN_25:   return COIN_VAL_W'(25);
      COIN_50:   return COIN_VAL_W'(50);
      COIN_100:  return COIN_VAL_W'(100);
      COIN_500:  return COIN_VAL_W'(500);
      COIN_1000: return COIN_VAL_W'(1000);
      COIN_2000: return COIN_VAL_W'(2000);
      COIN_5000: return COIN_VAL_W'(5000);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/vm_item_table.sv
// Item/price table: parallel match on one key, synchronous insert/update/delete
// at that key, and a running count of valid entries.
module vm_item_table #(
  parameter int unsigned SLOTS   = 16,
  parameter int unsigned ITEM_W  = 4,
  parameter int unsigned PRICE_W = 14,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ITEM_W-1:0]  key_i,
  input  logic               wr_en_i,
  input  logic [PRICE_W-1:0] wr_price_i,
  output logic               hit_c,
  output logic [PRICE_W-1:0] price_c,
  output logic               full_c,
  output logic [CNT_W-1:0]   count_o
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SLOTS-1:0]   valid_q;
  logic [ITEM_W-1:0]  item_q  [SLOTS];
  logic [PRICE_W-1:0] price_q [SLOTS];
  logic [CNT_W-1:0]   count_q;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   free_idx;

  // Key match and lowest free slot; keys are unique so at most one hit.
  always_comb begin
    hit_c    = 1'b0;
    hit_idx  = '0;
    price_c  = '0;
    full_c   = 1'b1;
    free_idx = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (valid_q[i] && item_q[i] == key_i) begin
        hit_c   = 1'b1;
        hit_idx = IDX_W'(i);
        price_c = price_q[i];
      end
      if (!valid_q[i] && full_c) begin
        full_c   = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        item_q[i]  <= '0;
        price_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      if (hit_c) begin
        if (wr_price_i == '0) begin
          valid_q[hit_idx] <= 1'b0;
          count_q          <= count_q - CNT_W'(1);
        end else begin
          price_q[hit_idx] <= wr_price_i;
        end
      end else if (wr_price_i != '0 && !full_c) begin
        valid_q[free_idx] <= 1'b1;
        item_q[free_idx]  <= key_i;
        price_q[free_idx] <= wr_price_i;
        count_q           <= count_q + CNT_W'(1);
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vending_fsm_param.sv
// Vending controller core: coin credit, item lookup, dispense and change
// handshakes, and runtime price table programming while idle.
module vending_fsm_param
  import vm_pkg::*;
#(
  parameter int unsigned SLOTS    = 16,
  parameter int unsigned ITEM_W   = 4,
  parameter int unsigned PRICE_W  = 14,
  parameter int unsigned BAL_MAX  = 9999,
  parameter logic [3:0]  PASSWORD = 4'b1010
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        coin_valid,
  input  logic [2:0]                  coin_code,
  input  logic                        select_valid,
  input  logic [ITEM_W-1:0]           select_item,
  input  logic                        cancel,
  input  logic                        admin_valid,
  input  logic [3:0]                  admin_pw,
  input  logic [ITEM_W-1:0]           admin_item,
  input  logic [PRICE_W-1:0]          admin_price,
  output logic                        vend_valid,
  output logic [ITEM_W-1:0]           vend_item,
  input  logic                        vend_ready,
  output logic                        change_valid,
  output logic [PRICE_W-1:0]          change_amount,
  input  logic                        change_ready,
  output logic [PRICE_W-1:0]          balance,
  output logic [2:0]                  state,
  output logic                        err_valid,
  output logic [2:0]                  err_code,
  output logic [$clog2(SLOTS+1)-1:0]  item_count
);

  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam int unsigned SUM_W = PRICE_W + 1;

  state_e             state_q, state_d;
  logic [PRICE_W-1:0] balance_q, balance_d;
  logic [ITEM_W-1:0]  sel_item_q, sel_item_d;
  logic               vend_valid_q, vend_valid_d;
  logic [ITEM_W-1:0]  vend_item_q, vend_item_d;
  logic               change_valid_q, change_valid_d;
  logic [PRICE_W-1:0] change_amount_q, change_amount_d;
  logic               err_valid_q, err_valid_d;
  logic [2:0]         err_code_q, err_code_d;

  coin_code_e         coin_e;
  logic [SUM_W-1:0]   coin_sum;
  logic               coin_ovf;
  logic [ITEM_W-1:0]  tbl_key;
  logic               tbl_wr;
  logic               tbl_hit;
  logic               tbl_full;
  logic [PRICE_W-1:0] tbl_price;

  // One extra bit of headroom so the credit limit compare cannot wrap.
  assign coin_e   = coin_code_e'(coin_code);
  assign coin_sum = {1'b0, balance_q} + SUM_W'(coin_value(coin_e));
  assign coin_ovf = coin_sum > SUM_W'(BAL_MAX);
  assign tbl_key  = (state_q == ST_LOOKUP) ? sel_item_q : admin_item;

  vm_item_table #(
    .SLOTS   (SLOTS),
    .ITEM_W  (ITEM_W),
    .PRICE_W (PRICE_W),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk        (clock),
    .rst_n      (reset_n),
    .key_i      (tbl_key),
    .wr_en_i    (tbl_wr),
    .wr_price_i (admin_price),
    .hit_c      (tbl_hit),
    .price_c    (tbl_price),
    .full_c     (tbl_full),
    .count_o    (item_count)
  );

  always_comb begin
    state_d         = state_q;
    balance_d       = balance_q;
    sel_item_d      = sel_item_q;
    vend_valid_d    = vend_valid_q;
    vend_item_d     = vend_item_q;
    change_valid_d  = change_valid_q;
    change_amount_d = change_amount_q;
    err_valid_d     = 1'b0;
    err_code_d      = ERR_NONE;
    tbl_wr          = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // cancel > coin > select; admin only reaches the table when idle.
        if (cancel) begin
          if (state_q == ST_CREDIT) begin
            state_d         = ST_CHANGE;
            change_valid_d  = 1'b1;
            change_amount_d = balance_q;
          end
        end else if (coin_valid) begin
          if (coin_e == COIN_BAD) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_COIN;
          end else if (coin_ovf) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVERFLOW;
          end else begin
            balance_d = coin_sum[PRICE_W-1:0];
            state_d   = ST_CREDIT;
          end
        end else if (state_q == ST_CREDIT) begin
          if (select_valid) begin
            sel_item_d = select_item;
            state_d    = ST_LOOKUP;
          end
        end else if (admin_valid) begin
          if (admin_pw != PASSWORD) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_PW;
          end else begin
            tbl_wr = 1'b1;
            if (!tbl_hit && admin_price != '0 && tbl_full) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_TABLE_FULL;
            end
          end
        end
      end
      ST_LOOKUP: begin
        if (!tbl_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_NOT_FOUND;
          state_d     = ST_CREDIT;
        end else if (tbl_price > balance_q) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_INSUFF;
          state_d     = ST_CREDIT;
        end else begin
          balance_d    = balance_q - tbl_price;
          vend_valid_d = 1'b1;
          vend_item_d  = sel_item_q;
          state_d      = ST_VEND;
        end
      end
      ST_VEND: begin
        if (vend_ready) begin
          vend_valid_d = 1'b0;
          vend_item_d  = '0;
          if (balance_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d         = ST_CHANGE;
            change_valid_d  = 1'b1;
            change_amount_d = balance_q;
          end
        end
      end
      ST_CHANGE: begin
        if (change_ready) begin
          change_valid_d  = 1'b0;
          change_amount_d = '0;
          balance_d       = '0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      balance_q       <= '0;
      sel_item_q      <= '0;
      vend_valid_q    <= 1'b0;
      vend_item_q     <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      err_valid_q     <= 1'b0;
      err_code_q      <= ERR_NONE;
    end else begin
      state_q         <= state_d;
      balance_q       <= balance_d;
      sel_item_q      <= sel_item_d;
      vend_valid_q    <= vend_valid_d;
      vend_item_q     <= vend_item_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      err_valid_q     <= err_valid_d;
      err_code_q      <= err_code_d;
    end
  end

  assign state         = state_q;
  assign balance       = balance_q;
  assign vend_valid    = vend_valid_q;
  assign vend_item     = vend_item_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Scoreboard bench for vending_fsm_param: a transaction-level model predicts
// errors, dispenses and change; a negedge monitor consumes them.
module tb_vending_fsm_param;

  localparam int unsigned SLOTS   = 16;
  localparam int unsigned ITEM_W  = 5;
  localparam int unsigned PRICE_W = 14;
  localparam int unsigned CNT_W   = $clog2(SLOTS + 1);
  localparam int          BAL_LIM = 9999;
  localparam int          PW      = 10;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                coin_valid;
  logic [2:0]          coin_code;
  logic                select_valid;
  logic [ITEM_W-1:0]   select_item;
  logic                cancel;
  logic                admin_valid;
  logic [3:0]          admin_pw;
  logic [ITEM_W-1:0]   admin_item;
  logic [PRICE_W-1:0]  admin_price;
  logic                vend_valid;
  logic [ITEM_W-1:0]   vend_item;
  logic                vend_ready;
  logic                change_valid;
  logic [PRICE_W-1:0]  change_amount;
  logic                change_ready;
  logic [PRICE_W-1:0]  balance;
  logic [2:0]          state;
  logic                err_valid;
  logic [2:0]          err_code;
  logic [CNT_W-1:0]    item_count;

  int checks = 0;
  int errors = 0;

  int mbal;
  int mtbl[int];
  int err_q[$];
  int vend_q[$];
  int change_q[$];
  int vend_delay   = 0;
  int change_delay = 0;

  vending_fsm_param #(
    .SLOTS    (SLOTS),
    .ITEM_W   (ITEM_W),
    .PRICE_W  (PRICE_W),
    .BAL_MAX  (9999),
    .PASSWORD (4'b1010)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .select_valid  (select_valid),
    .select_item   (select_item),
    .cancel        (cancel),
    .admin_valid   (admin_valid),
    .admin_pw      (admin_pw),
    .admin_item    (admin_item),
    .admin_price   (admin_price),
    .vend_valid    (vend_valid),
    .vend_item     (vend_item),
    .vend_ready    (vend_ready),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .balance       (balance),
    .state         (state),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .item_count    (item_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, required no such output", name, act);
  endtask

  function automatic int coin_cents(input int code);
    case (code)
      0: return 25;
      1: return 50;
      2: return 100;
      3: return 500;
      4: return 1000;
      5: return 2000;
      6: return 5000;
      default: return 0;
    endcase
  endfunction

  // Monitor: consumes expected errors, dispenses and change amounts.
  always @(negedge clock) begin
    if (reset_n) begin
      if (err_valid) begin
        if (err_q.size() == 0) unexpected("err_unexpected", int'(err_code));
        else chk("err_code", int'(err_code), err_q.pop_front());
      end
      if (vend_valid) begin
        if (vend_q.size() == 0) unexpected("vend_unexpected", int'(vend_item));
        else begin
          chk("vend_item", int'(vend_item), vend_q[0]);
          if (vend_ready) void'(vend_q.pop_front());
        end
      end
      if (change_valid) begin
        if (change_q.size() == 0) unexpected("change_unexpected", int'(change_amount));
        else begin
          chk("change_amount", int'(change_amount), change_q[0]);
          if (change_ready) void'(change_q.pop_front());
        end
      end
    end
  end

  // Dispenser and changer: accept after a programmable number of waiting cycles.
  initial begin
    int vwait = 0;
    int cwait = 0;
    vend_ready   = 1'b0;
    change_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) begin
        vend_ready = 1'b0; change_ready = 1'b0; vwait = 0; cwait = 0;
      end else begin
        if (vend_ready) begin vend_ready = 1'b0; vwait = 0; end
        else if (vend_valid) begin
          if (vwait >= vend_delay) vend_ready = 1'b1; else vwait++;
        end
        if (change_ready) begin change_ready = 1'b0; cwait = 0; end
        else if (change_valid) begin
          if (cwait >= change_delay) change_ready = 1'b1; else cwait++;
        end
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clock); #1;
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0; admin_valid = 1'b0;
  endtask

  // Wait for IDLE/CREDIT, then compare architectural state against the model.
  task automatic settle();
    int n = 0;
    while (!(state == 3'd0 || state == 3'd1) && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL settle_timeout: state %0d, required IDLE or CREDIT within 100 cycles", state);
    end
    @(negedge clock); #1;
    chk("balance", int'(balance), mbal);
    chk("state", int'(state), (mbal > 0) ? 1 : 0);
    chk("item_count", int'(item_count), mtbl.num());
    chk("events_pending", err_q.size() + vend_q.size() + change_q.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vend_valid"}, int'(vend_valid), 0);
    chk({tag, "_vend_item"}, int'(vend_item), 0);
    chk({tag, "_change_valid"}, int'(change_valid), 0);
    chk({tag, "_change_amount"}, int'(change_amount), 0);
    chk({tag, "_balance"}, int'(balance), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_err_valid"}, int'(err_valid), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_item_count"}, int'(item_count), 0);
  endtask

  task automatic op_coin(input int code);
    if (code == 7) err_q.push_back(1);
    else if (mbal + coin_cents(code) > BAL_LIM) err_q.push_back(2);
    else mbal += coin_cents(code);
    coin_valid = 1'b1; coin_code = 3'(code);
    drive_cycle();
    settle();
  endtask

  task automatic op_select(input int item);
    bit in_credit = (mbal > 0);
    bit will_vend = 1'b0;
    int vbal = mbal;
    if (in_credit) begin
      if (!mtbl.exists(item)) err_q.push_back(3);
      else if (mtbl[item] > mbal) err_q.push_back(4);
      else begin
        will_vend = 1'b1;
        vbal = mbal - mtbl[item];
        vend_q.push_back(item);
        if (vbal > 0) change_q.push_back(vbal);
      end
    end
    select_valid = 1'b1; select_item = ITEM_W'(item);
    drive_cycle();
    if (in_credit) begin
      chk("lookup_state", int'(state), 2);
      @(posedge clock); #1;
      chk("post_lookup_state", int'(state), will_vend ? 3 : 1);
      if (will_vend) chk("vend_balance", int'(balance), vbal);
    end
    if (will_vend) mbal = 0;
    settle();
  endtask

  task automatic op_cancel();
    if (mbal > 0) change_q.push_back(mbal);
    mbal = 0;
    cancel = 1'b1;
    drive_cycle();
    settle();
  endtask

  task automatic op_admin(input int pw, input int item, input int price);
    if (mbal > 0) begin
    end else if (pw != PW) err_q.push_back(5);
    else if (mtbl.exists(item)) begin
      if (price == 0) mtbl.delete(item); else mtbl[item] = price;
    end else if (price != 0) begin
      if (mtbl.num() >= int'(SLOTS)) err_q.push_back(6); else mtbl[item] = price;
    end
    admin_valid = 1'b1; admin_pw = 4'(pw); admin_item = ITEM_W'(item); admin_price = PRICE_W'(price);
    drive_cycle();
    settle();
  endtask

  initial begin
    reset_n = 1'b0;
    coin_valid = 1'b0; coin_code = '0; select_valid = 1'b0; select_item = '0;
    cancel = 1'b0; admin_valid = 1'b0; admin_pw = '0; admin_item = '0; admin_price = '0;
    mbal = 0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    op_admin(PW, 3, 150);
    op_admin(1, 3, 150);

    op_coin(2); op_coin(1);
    op_select(3);

    vend_delay = 4; change_delay = 2;
    op_coin(3);
    op_select(3);
    vend_delay = 0; change_delay = 0;

    op_coin(6); op_coin(6); op_coin(7);
    op_select(9);
    op_cancel();

    for (int i = 0; i < 16; i++) if (i != 3) op_admin(PW, i, 100 + i * 25);
    op_admin(PW, 20, 300);
    op_admin(PW, 3, 0);
    op_admin(PW, 20, 300);
    op_coin(3);
    op_select(20);

    // Simultaneous strobes: coin beats select, cancel beats coin.
    op_coin(0);
    mbal += 50;
    coin_valid = 1'b1; coin_code = 3'd1; select_valid = 1'b1; select_item = ITEM_W'(3);
    drive_cycle();
    chk("coin_over_select_state", int'(state), 1);
    settle();
    change_q.push_back(mbal); mbal = 0;
    cancel = 1'b1; coin_valid = 1'b1; coin_code = 3'd2;
    drive_cycle();
    settle();

    // Reset while an item is being offered to the dispenser.
    op_coin(3);
    vend_delay = 1000;
    vend_q.push_back(5);
    select_valid = 1'b1; select_item = ITEM_W'(5);
    drive_cycle();
    @(posedge clock); #1;
    chk("vend_before_reset", int'(vend_valid), 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset_in_vend");
    mbal = 0; mtbl.delete(); err_q.delete(); vend_q.delete(); change_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    vend_delay = 0;
    @(posedge clock); #1;

    for (int n = 0; n < 400; n++) begin
      int r;
      vend_delay   = int'($urandom_range(0, 5));
      change_delay = int'($urandom_range(0, 5));
      r = int'($urandom_range(0, 99));
      if (r < 35) begin
        op_coin(($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6)));
      end else if (r < 62) begin
        op_select(int'($urandom_range(0, 31)));
      end else if (r < 70) begin
        op_cancel();
      end else begin
        int pw    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : PW;
        int price = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 80)) * 25;
        op_admin(pw, int'($urandom_range(0, 31)), price);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
